// File: rtl/vector_register_read_unit_if.sv
// Bundles the request, write-back and operand-output signals of the
// vector register-read stage. The master side is the issue/execute
// environment; the slave side is the read unit itself.
interface vector_register_read_unit_if #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REGS   = 32,
   parameter int NUM_PORTS  = 4,
   parameter int TAG_LENGTH = $clog2(NUM_REGS)
);
   // request from decode/issue
   logic                                 req_valid;
   logic                                 req_ready;
   logic [NUM_PORTS-1:0]                 req_port_enable;
   logic [NUM_PORTS-1:0][TAG_LENGTH-1:0] req_address;
   logic                                 req_writes_vd;
   logic [TAG_LENGTH-1:0]                req_vd_address;

   // write-back from the execute lanes
   logic                                 wb_valid;
   logic [TAG_LENGTH-1:0]                wb_tag;
   logic [DATA_WIDTH-1:0]                wb_data;

   // operand packet towards the execute lanes
   logic                                 out_valid;
   logic                                 out_ready;
   logic [NUM_PORTS-1:0][TAG_LENGTH-1:0] out_tag;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_data;

   // pending-write scoreboard
   logic [NUM_REGS-1:0]                  busy_vector;

   modport master (
      output req_valid, req_port_enable, req_address, req_writes_vd, req_vd_address,
      output wb_valid, wb_tag, wb_data,
      output out_ready,
      input  req_ready, out_valid, out_tag, out_data, busy_vector
   );

   modport slave (
      input  req_valid, req_port_enable, req_address, req_writes_vd, req_vd_address,
      input  wb_valid, wb_tag, wb_data,
      input  out_ready,
      output req_ready, out_valid, out_tag, out_data, busy_vector
   );
endinterface

// File: rtl/vector_register_read_unit.sv
// Vector register-read stage: multi-port register file with write-back
// bypass, a pending-write scoreboard that stalls RAW/WAW hazards, and a
// single registered valid/ready operand slot towards execute.
module vector_register_read_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REGS   = 32,
   parameter int NUM_PORTS  = 4,
   parameter int TAG_LENGTH = $clog2(NUM_REGS)
) (
   input logic                         clock,
   input logic                         reset,
   vector_register_read_unit_if.slave  bus
);

   // The output slot is either empty or holding a packet for execute.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   slot_state_t                          state_reg, state_next;

   logic [DATA_WIDTH-1:0]                regfile_reg [NUM_REGS];
   logic [NUM_REGS-1:0]                  busy_reg, busy_next;
   logic [NUM_PORTS-1:0][TAG_LENGTH-1:0] out_tag_reg, out_tag_next;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_data_reg, out_data_next;

   logic [NUM_PORTS-1:0]                 port_bypass;
   logic [NUM_PORTS-1:0]                 port_hazard;
   logic [NUM_PORTS-1:0][TAG_LENGTH-1:0] accept_tag;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] accept_data;

   logic vd_bypass;
   logic vd_hazard;
   logic hazard;
   logic slot_free;
   logic req_ready_int;
   logic accept;

   // Per-port read path: a write-back to the same register this cycle both
   // supplies the data (bypass) and removes the pending-write stall.
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign port_bypass[gi] = bus.wb_valid && (bus.wb_tag == bus.req_address[gi]);
         assign port_hazard[gi] = bus.req_port_enable[gi]
                                  && busy_reg[bus.req_address[gi]]
                                  && !port_bypass[gi];
         assign accept_tag[gi]  = bus.req_port_enable[gi] ? bus.req_address[gi] : '0;
         assign accept_data[gi] = !bus.req_port_enable[gi] ? '0 :
                                  port_bypass[gi]          ? bus.wb_data :
                                                             regfile_reg[bus.req_address[gi]];
      end
   endgenerate

   // A destination that is still pending would reorder two writes (WAW)
   // unless the pending write retires in this very cycle.
   assign vd_bypass = bus.wb_valid && (bus.wb_tag == bus.req_vd_address);
   assign vd_hazard = bus.req_writes_vd && busy_reg[bus.req_vd_address] && !vd_bypass;
   assign hazard    = (|port_hazard) || vd_hazard;

   // The slot can take a new packet when empty or when its packet leaves now.
   assign slot_free     = (state_reg == SLOT_EMPTY) || bus.out_ready;
   assign req_ready_int = !reset && !hazard && slot_free;
   assign accept        = bus.req_valid && req_ready_int;

   assign bus.req_ready   = req_ready_int;
   assign bus.out_valid   = (state_reg == SLOT_FULL);
   assign bus.out_tag     = out_tag_reg;
   assign bus.out_data    = out_data_reg;
   assign bus.busy_vector = busy_reg;

   // Output slot next state: load on accept, drain when consumed, else hold.
   always_comb begin
      state_next    = state_reg;
      out_tag_next  = out_tag_reg;
      out_data_next = out_data_reg;
      case (state_reg)
         SLOT_EMPTY: begin
            if (accept) begin
               state_next    = SLOT_FULL;
               out_tag_next  = accept_tag;
               out_data_next = accept_data;
            end
         end
         SLOT_FULL: begin
            if (accept) begin
               out_tag_next  = accept_tag;
               out_data_next = accept_data;
            end else if (bus.out_ready) begin
               state_next = SLOT_EMPTY;
            end
         end
         default: begin
            state_next = SLOT_EMPTY;
         end
      endcase
   end

   // Scoreboard update: the set from a new producer is applied after the
   // clear from write-back so a same-register collision leaves it pending.
   always_comb begin
      busy_next = busy_reg;
      if (bus.wb_valid) begin
         busy_next[bus.wb_tag] = 1'b0;
      end
      if (accept && bus.req_writes_vd) begin
         busy_next[bus.req_vd_address] = 1'b1;
      end
   end

   // Slot and scoreboard registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= SLOT_EMPTY;
         out_tag_reg  <= '0;
         out_data_reg <= '0;
         busy_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         out_tag_reg  <= out_tag_next;
         out_data_reg <= out_data_next;
         busy_reg     <= busy_next;
      end
   end

   // Register file: cleared on reset, written by write-back otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regfile_reg[i] <= '0;
         end
      end else if (bus.wb_valid) begin
         regfile_reg[bus.wb_tag] <= bus.wb_data;
      end
   end

endmodule

// File: tb/tb_vector_register_read_unit.sv
// Bench for vector_register_read_unit: directed scenarios with fixed
// expected values plus a randomized run against a behavioural model.
module tb_vector_register_read_unit;
   localparam int DW = 64;
   localparam int NR = 32;
   localparam int NP = 4;
   localparam int TL = $clog2(NR);

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   vector_register_read_unit_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_PORTS(NP), .TAG_LENGTH(TL)) bus ();

   vector_register_read_unit #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_PORTS(NP), .TAG_LENGTH(TL)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int passed = 0;

   // behavioural model state
   logic [DW-1:0] m_regs [NR];
   bit            m_busy [NR];
   bit            m_valid;
   logic [TL-1:0] m_tag  [NP];
   logic [DW-1:0] m_data [NP];
   bit            last_accept;

   localparam logic [DW-1:0] BEEF = 64'hDEAD_BEEF_0000_0001;

   task automatic idle();
      bus.req_valid       = 1'b0;
      bus.req_port_enable = '0;
      bus.req_address     = '0;
      bus.req_writes_vd   = 1'b0;
      bus.req_vd_address  = '0;
      bus.wb_valid        = 1'b0;
      bus.wb_tag          = '0;
      bus.wb_data         = '0;
      bus.out_ready       = 1'b1;
   endtask

   function automatic bit is_cleared_now(input logic [TL-1:0] r);
      return bus.wb_valid && (bus.wb_tag == r);
   endfunction

   // Readiness from the rules: no stall on a pending register that is not
   // being written back now, and room in the single output slot.
   function automatic bit model_ready();
      if (reset) return 1'b0;
      if (m_valid && !bus.out_ready) return 1'b0;
      for (int p = 0; p < NP; p++)
         if (bus.req_port_enable[p] && m_busy[bus.req_address[p]] && !is_cleared_now(bus.req_address[p]))
            return 1'b0;
      if (bus.req_writes_vd && m_busy[bus.req_vd_address] && !is_cleared_now(bus.req_vd_address))
         return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [NR-1:0] exp_busy();
      logic [NR-1:0] v;
      for (int r = 0; r < NR; r++) v[r] = m_busy[r];
      return v;
   endfunction

   function automatic logic [NP-1:0][TL-1:0] exp_tags();
      logic [NP-1:0][TL-1:0] v;
      for (int p = 0; p < NP; p++) v[p] = m_tag[p];
      return v;
   endfunction

   function automatic logic [NP-1:0][DW-1:0] exp_datas();
      logic [NP-1:0][DW-1:0] v;
      for (int p = 0; p < NP; p++) v[p] = m_data[p];
      return v;
   endfunction

   // Advance one rising edge and apply the same edge to the model.
   task automatic tick();
      bit            acc;
      logic [DW-1:0] rd [NP];
      acc = bus.req_valid && model_ready();
      for (int p = 0; p < NP; p++) begin
         if (!bus.req_port_enable[p])               rd[p] = '0;
         else if (is_cleared_now(bus.req_address[p])) rd[p] = bus.wb_data;
         else                                        rd[p] = m_regs[bus.req_address[p]];
      end
      @(posedge clock);
      if (reset) begin
         m_valid = 1'b0;
         for (int p = 0; p < NP; p++) begin m_tag[p] = '0; m_data[p] = '0; end
         for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
      end else begin
         if (acc) begin
            m_valid = 1'b1;
            for (int p = 0; p < NP; p++) begin
               m_tag[p]  = bus.req_port_enable[p] ? bus.req_address[p] : '0;
               m_data[p] = rd[p];
            end
            $display("accept t=%0t en=%b writes_vd=%0b vd=%0d", $time, bus.req_port_enable,
                     bus.req_writes_vd, bus.req_vd_address);
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
         if (bus.wb_valid) begin
            m_regs[bus.wb_tag] = bus.wb_data;
            m_busy[bus.wb_tag] = 1'b0;
         end
         if (acc && bus.req_writes_vd) m_busy[bus.req_vd_address] = 1'b1;
      end
      last_accept = acc;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passed++;
      checks++; if (bus.busy_vector !== '0) $display("FAIL reset_busy: got %h expected 0", bus.busy_vector); else passed++;
      checks++; if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", bus.out_data); else passed++;
      checks++; if (bus.out_tag !== '0) $display("FAIL reset_out_tag: got %h expected 0", bus.out_tag); else passed++;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); else passed++;
   endtask

   task automatic test_readback();
      logic [NP-1:0][DW-1:0] want;
      idle();
      bus.wb_valid = 1'b1; bus.wb_tag = 5; bus.wb_data = BEEF;
      tick();
      idle();
      bus.req_valid = 1'b1; bus.req_port_enable = 4'b0010; bus.req_address[1] = 5;
      #1;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL readback_ready: got %b expected 1", bus.req_ready); else passed++;
      tick();
      idle();
      want = '0; want[1] = BEEF;
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL readback_valid: got %b expected 1", bus.out_valid); else passed++;
      checks++; if (bus.out_tag[1] !== TL'(5)) $display("FAIL readback_tag: got %0d expected 5", bus.out_tag[1]); else passed++;
      checks++; if (bus.out_data !== want) $display("FAIL readback_data: got %h expected %h", bus.out_data, want); else passed++;
      tick();
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL readback_drain: got %b expected 0", bus.out_valid); else passed++;
   endtask

   task automatic test_bypass();
      idle();
      bus.wb_valid = 1'b1; bus.wb_tag = 7; bus.wb_data = 64'h1234;
      bus.req_valid = 1'b1; bus.req_port_enable = 4'b0100; bus.req_address[2] = 7;
      #1;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL bypass_ready: got %b expected 1", bus.req_ready); else passed++;
      tick();
      idle();
      checks++; if (bus.out_data[2] !== 64'h1234) $display("FAIL bypass_data: got %h expected 1234", bus.out_data[2]); else passed++;
      checks++; if (bus.out_tag[2] !== TL'(7)) $display("FAIL bypass_tag: got %0d expected 7", bus.out_tag[2]); else passed++;
      tick();
   endtask

   task automatic test_raw_stall();
      idle();
      bus.req_valid = 1'b1; bus.req_writes_vd = 1'b1; bus.req_vd_address = 3;
      tick();
      idle();
      checks++; if (bus.busy_vector[3] !== 1'b1) $display("FAIL raw_busy_set: got %b expected 1", bus.busy_vector[3]); else passed++;
      bus.req_valid = 1'b1; bus.req_port_enable = 4'b0010; bus.req_address[1] = 3;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus.req_ready !== 1'b0) $display("FAIL raw_stall: cycle %0d got %b expected 0", c, bus.req_ready); else passed++;
         tick();
      end
      bus.wb_valid = 1'b1; bus.wb_tag = 3; bus.wb_data = 64'h55;
      #1;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL raw_release: got %b expected 1", bus.req_ready); else passed++;
      tick();
      idle();
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL raw_valid: got %b expected 1", bus.out_valid); else passed++;
      checks++; if (bus.out_data[1] !== 64'h55) $display("FAIL raw_data: got %h expected 55", bus.out_data[1]); else passed++;
      checks++; if (bus.busy_vector[3] !== 1'b0) $display("FAIL raw_busy_clear: got %b expected 0", bus.busy_vector[3]); else passed++;
      tick();
   endtask

   task automatic test_waw();
      idle();
      bus.req_valid = 1'b1; bus.req_writes_vd = 1'b1; bus.req_vd_address = 9;
      tick();
      idle();
      checks++; if (bus.busy_vector[9] !== 1'b1) $display("FAIL waw_busy_set: got %b expected 1", bus.busy_vector[9]); else passed++;
      bus.req_valid = 1'b1; bus.req_writes_vd = 1'b1; bus.req_vd_address = 9;
      bus.wb_valid = 1'b1; bus.wb_tag = 9; bus.wb_data = 64'h99;
      #1;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL waw_ready: got %b expected 1", bus.req_ready); else passed++;
      tick();
      idle();
      checks++; if (bus.busy_vector[9] !== 1'b1) $display("FAIL waw_set_wins: got %b expected 1", bus.busy_vector[9]); else passed++;
      bus.wb_valid = 1'b1; bus.wb_tag = 9; bus.wb_data = 64'h99;
      tick();
      idle();
      checks++; if (bus.busy_vector !== '0) $display("FAIL waw_final_busy: got %h expected 0", bus.busy_vector); else passed++;
   endtask

   task automatic test_backpressure();
      idle();
      bus.out_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_port_enable = 4'b0001; bus.req_address[0] = 5;
      tick();
      bus.req_port_enable = 4'b0010; bus.req_address[0] = 0; bus.req_address[1] = 7;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus.req_ready !== 1'b0) $display("FAIL bp_ready: cycle %0d got %b expected 0", c, bus.req_ready); else passed++;
         checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid: cycle %0d got %b expected 1", c, bus.out_valid); else passed++;
         checks++; if (bus.out_data[0] !== BEEF || bus.out_tag[0] !== TL'(5))
            $display("FAIL bp_hold: cycle %0d got %h/%0d expected %h/5", c, bus.out_data[0], bus.out_tag[0], BEEF);
         else passed++;
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL bp_release: got %b expected 1", bus.req_ready); else passed++;
      tick();
      idle();
      checks++; if (bus.out_data[1] !== 64'h1234 || bus.out_data[0] !== '0)
         $display("FAIL bp_next_packet: got %h/%h expected 1234/0", bus.out_data[1], bus.out_data[0]);
      else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      idle();
      bus.req_valid = 1'b1; bus.req_port_enable = 4'b0001; bus.req_address[0] = 5;
      bus.req_writes_vd = 1'b1; bus.req_vd_address = 4;
      tick();
      idle();
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.busy_vector[4] !== 1'b1)
         $display("FAIL midrst_setup: got valid=%b busy4=%b expected 1/1", bus.out_valid, bus.busy_vector[4]);
      else passed++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); else passed++;
      checks++; if (bus.busy_vector !== '0) $display("FAIL midrst_busy: got %h expected 0", bus.busy_vector); else passed++;
      bus.out_ready = 1'b1;
      bus.req_valid = 1'b1; bus.req_port_enable = 4'b0011; bus.req_address[0] = 4; bus.req_address[1] = 5;
      #1;
      checks++; if (bus.req_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", bus.req_ready); else passed++;
      tick();
      idle();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== '0)
         $display("FAIL midrst_read: got valid=%b data=%h expected 1/0", bus.out_valid, bus.out_data);
      else passed++;
      tick();
   endtask

   task automatic test_random(input int cycles);
      idle();
      for (int i = 0; i < cycles; i++) begin
         if (!(bus.req_valid && !last_accept)) begin
            bus.req_valid       = ($urandom_range(3) != 0);
            bus.req_port_enable = NP'($urandom);
            for (int p = 0; p < NP; p++) bus.req_address[p] = TL'($urandom_range(7));
            bus.req_writes_vd   = $urandom_range(1) == 1;
            bus.req_vd_address  = TL'($urandom_range(7));
         end
         bus.wb_valid  = ($urandom_range(2) == 0);
         bus.wb_tag    = TL'($urandom_range(7));
         bus.wb_data   = {$urandom, $urandom};
         bus.out_ready = ($urandom_range(3) != 0);
         reset         = ($urandom_range(63) == 0);
         #1;
         if (!reset) begin
            checks++; if (bus.req_ready !== model_ready())
               $display("FAIL rand_ready: cycle %0d got %b expected %b", i, bus.req_ready, model_ready());
            else passed++;
         end
         tick();
         checks++; if (bus.out_valid !== m_valid) $display("FAIL rand_valid: cycle %0d got %b expected %b", i, bus.out_valid, m_valid); else passed++;
         checks++; if (bus.busy_vector !== exp_busy()) $display("FAIL rand_busy: cycle %0d got %h expected %h", i, bus.busy_vector, exp_busy()); else passed++;
         if (m_valid) begin
            checks++; if (bus.out_tag !== exp_tags()) $display("FAIL rand_tag: cycle %0d got %h expected %h", i, bus.out_tag, exp_tags()); else passed++;
            checks++; if (bus.out_data !== exp_datas()) $display("FAIL rand_data: cycle %0d got %h expected %h", i, bus.out_data, exp_datas()); else passed++;
         end
      end
      reset = 1'b0;
      idle();
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      last_accept = 1'b0;
      test_reset();
      test_readback();
      test_bypass();
      test_raw_stall();
      test_waw();
      test_backpressure();
      test_reset_mid();
      test_random(500);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/vector_register_read_unit.md
# vector_register_read_unit

Parametrised vector register-read stage: a NUM_REGS x DATA_WIDTH register file with NUM_PORTS operand read ports, same-cycle write-back bypass, a pending-write scoreboard that stalls RAW/WAW hazards, and a registered valid/ready output. It sits between vector decode/issue and the vector execute lanes. It replaces the fixed four-operand, handshake-free register-read stage.

## Interface
Parameters:
- DATA_WIDTH, 64, bits per vector register element word
- NUM_REGS, 32, architectural vector registers
- NUM_PORTS, 4, operand read ports (port 0 = v0/mask, 1 = vs1, 2 = vs2, 3 = vd by convention)
- TAG_LENGTH, $clog2(NUM_REGS), derived; do not override

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  read request present
- req_ready  out  1  request accepted this cycle when both high
- req_port_enable  in  NUM_PORTS  per-port read enable
- req_address  in  NUM_PORTS x TAG_LENGTH  per-port register address
- req_writes_vd  in  1  request will produce a result into req_vd_address
- req_vd_address  in  TAG_LENGTH  destination register to mark pending
- wb_valid  in  1  write-back present
- wb_tag  in  TAG_LENGTH  write-back register
- wb_data  in  DATA_WIDTH  write-back data
- out_valid  out  1  operand packet valid
- out_ready  in  1  downstream accepts packet
- out_tag  out  NUM_PORTS x TAG_LENGTH  per-port register tag
- out_data  out  NUM_PORTS x DATA_WIDTH  per-port operand data
- busy_vector  out  NUM_REGS  scoreboard, bit r = write to r pending

## Operation
- Write-back: wb_valid writes wb_data to reg[wb_tag] at the edge and clears busy[wb_tag]; never stalled.
- Hazard (combinational): any enabled port p with busy[req_address[p]] and not (wb_valid and wb_tag == req_address[p]); or req_writes_vd with busy[req_vd_address] not cleared by this cycle's write-back.
- req_ready = !hazard and (!out_valid or out_ready). req_* fields must be stable while req_valid is high and unaccepted.
- Accept (req_valid and req_ready): per port, enabled -> out_tag = address, out_data = wb_data if wb_valid and wb_tag matches, else reg[address]; disabled -> tag 0, data 0. out_valid <= 1.
- Accept with req_writes_vd sets busy[req_vd_address]; if the same cycle's write-back clears that tag, set wins.
- out_valid <= 0 when out_ready and no accept. Output holds stable while out_valid and !out_ready.
- Reset: out_valid 0, out_tag/out_data 0, busy_vector 0, all registers 0; request and write-back in the reset cycle ignored.

## Timing
- Accept-to-out_valid latency: 1 cycle; throughput 1 packet/cycle with out_ready held high.
- Write-back visible to a read accepted in the same cycle (bypass); reg file updated next edge.
- Stall released the cycle the blocking write-back arrives (combinational clear via bypass).
- Reset mid-operation: pending packet dropped, scoreboard cleared, next cycle req_ready follows normal rule.
- busy_vector reflects registered state (post-edge), no combinational path from inputs.

## Test plan
- Reset then write-back tag 5 = 0xDEAD_BEEF_0000_0001; next cycle read port 1 addr 5 -> one cycle later out_valid=1, out_tag[1]=5, out_data[1]=0xDEAD_BEEF_0000_0001, other disabled ports 0.
- Same-cycle bypass: wb_valid tag 7 data 0x1234 with read port 2 addr 7 -> out_data[2]=0x1234 next cycle.
- RAW stall: accept request writes_vd=1 vd=3; next request reads addr 3 -> req_ready=0 until wb_valid tag 3 data 0x55, in that cycle req_ready=1 and out_data=0x55; busy_vector[3] cleared.
- WAW set-wins: busy[9]=1, request writes_vd vd=9 with wb_valid tag 9 same cycle -> accepted, busy_vector[9]=1 afterwards.
- Backpressure: out_ready=0 for 3 cycles with a valid packet -> out_valid/out_data stable, req_ready=0; out_ready=1 -> new request accepted same cycle.
- Reset with out_valid=1 and busy[4]=1 -> next cycle out_valid=0, busy_vector=0, reading addr 4 returns 0.
